// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first subtractor: diff = a - b (mod 2^WIDTH), borrow = (a < b).
//   One full-subtractor cell plus a borrow flop, iterated over WIDTH cycles.
//   Optional macro SERIAL_SUBTRACTOR_OVF_EN adds a two's-complement overflow output.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   start   in   request, accepted only while ready=1
//   a, b    in   minuend / subtrahend, sampled on the accepting edge
//   ready   out  high only in IDLE
//   diff    out  result, held until the next completion
//   borrow  out  unsigned borrow-out, held with diff
//   done    out  one-cycle pulse when diff/borrow are updated
//   ovf     out  (SERIAL_SUBTRACTOR_OVF_EN only) signed overflow, held with diff
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   output logic             ovf,
`endif
   output logic             done
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;
   logic [WIDTH-1:0]   sb_q, sb_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               br_q, br_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   // Full-subtractor cell on the current LSBs.
   logic             x, y, d_bit, br_next;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      x        = sa_q[0];
      y        = sb_q[0];
      d_bit    = x ^ y ^ br_q;
      br_next  = (~x & y) | (~(x ^ y) & br_q);
      // Concatenate-then-shift keeps this legal for WIDTH=1.
      res_next = WIDTH'({d_bit, res_q} >> 1);
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               sa_d    = a;
               sb_d    = b;
               br_d    = 1'b0;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            res_d = res_next;
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            br_d  = br_next;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = DONE;
               diff_d   = res_next;
               borrow_d = br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               // On the last step x/y are the operand MSBs and d_bit is diff's MSB.
               ovf_d    = (x != y) && (d_bit != x);
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
      done_d  = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign ready  = ready_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed self-checking bench for serial_subtractor (WIDTH=8).
//   Covers the ovf output when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         ovf;
`endif

   int checks;
   int errors;

   // Results captured by run_op.
   logic [W-1:0] r_diff;
   logic         r_borrow;
   logic         r_ovf;
   int           r_done_cnt;
   int           r_done_cycle;
   int           r_ready_low;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .ready  (ready),
      .diff   (diff),
      .borrow (borrow),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      .ovf    (ovf),
`endif
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation and observe it until ready returns.
   // r_done_cycle counts cycles from the accept edge (cycle 1 = after that edge).
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
      int n;
      n = 0;
      while (!ready && n < 40) begin
         tick();
         n++;
      end
      r_done_cnt   = 0;
      r_done_cycle = -1;
      r_ready_low  = 0;
      r_diff       = 'x;
      r_borrow     = 1'bx;
      r_ovf        = 1'b0;
      start = 1'b1;
      a     = av;
      b     = bv;
      tick();
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (done) begin
            r_done_cnt++;
            r_done_cycle = i + 1;
            r_diff       = diff;
            r_borrow     = borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_ovf        = ovf;
`endif
         end
         if (ready) break;
         r_ready_low++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      a = 8'hFF;
      b = 8'h01;
      tick();
      tick();
      rst = 1'b0;
      start = 1'b0;
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ready=%b done=%b diff=%h borrow=%b, want 1 0 00 0",
                  ready, done, diff, borrow);
      end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf: ovf=%b want 0", ovf);
      end
`endif
      // A start held through reset must not have been accepted.
      tick();
      checks++;
      if (done !== 1'b0 || diff !== 8'h00) begin
         errors++;
         $display("FAIL reset_start_ignored: done=%b diff=%h want 0 00", done, diff);
      end
   endtask

   task automatic test_basic();
      run_op(8'h05, 8'h03);
      checks++;
      if (r_done_cycle !== 9 || r_done_cnt !== 1) begin
         errors++;
         $display("FAIL basic_latency: done_cycle=%0d count=%0d want 9 1", r_done_cycle, r_done_cnt);
      end
      checks++;
      if (r_ready_low !== 9) begin
         errors++;
         $display("FAIL basic_ready_low: %0d cycles want 9", r_ready_low);
      end
      checks++;
      if (r_diff !== 8'h02 || r_borrow !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: diff=%h borrow=%b want 02 0", r_diff, r_borrow);
      end
   endtask

   task automatic test_patterns();
      logic [W-1:0] va [4];
      logic [W-1:0] vb [4];
      logic [W-1:0] vd [4];
      logic         vbr [4];
      va = '{8'h03, 8'h00, 8'hFF, 8'h00};
      vb = '{8'h05, 8'h01, 8'hFF, 8'h00};
      vd = '{8'hFE, 8'hFF, 8'h00, 8'h00};
      vbr = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i]);
         checks++;
         if (r_done_cnt !== 1 || r_diff !== vd[i] || r_borrow !== vbr[i]) begin
            errors++;
            $display("FAIL pattern_%0d: %h-%h diff=%h borrow=%b dones=%0d want %h %b 1",
                     i, va[i], vb[i], r_diff, r_borrow, r_done_cnt, vd[i], vbr[i]);
         end
      end
   endtask

   task automatic test_ignored_start();
      int dones;
      logic [W-1:0] dseen;
      logic         bseen;
      int quiet_bad;
      dones = 0;
      dseen = 'x;
      bseen = 1'bx;
      quiet_bad = 0;
      start = 1'b1;
      a = 8'h10;
      b = 8'h01;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      a = 8'hAA;
      b = 8'h55;
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            dones++;
            dseen = diff;
            bseen = borrow;
         end
         if (ready) break;
         tick();
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done || !ready) quiet_bad++;
      end
      checks++;
      if (dones !== 1 || dseen !== 8'h0F || bseen !== 1'b0) begin
         errors++;
         $display("FAIL ignored_start: dones=%0d diff=%h borrow=%b want 1 0f 0", dones, dseen, bseen);
      end
      checks++;
      if (quiet_bad !== 0) begin
         errors++;
         $display("FAIL ignored_start_queued: %0d busy/done cycles after completion want 0", quiet_bad);
      end
   endtask

   task automatic test_back_to_back();
      int pulses;
      int last;
      int bad_gap;
      int bad_diff;
      pulses = 0;
      last = -1;
      bad_gap = 0;
      bad_diff = 0;
      a = 8'h20;
      b = 8'h10;
      for (int k = 1; k <= 45; k++) begin
         start = (k <= 30);
         tick();
         if (done) begin
            pulses++;
            if (last >= 0 && (k - last) != 10) bad_gap++;
            if (last < 0 && k != 9) bad_gap++;
            last = k;
         end
         if (k >= 9 && diff !== 8'h10) bad_diff++;
      end
      start = 1'b0;
      checks++;
      if (pulses !== 3 || bad_gap !== 0) begin
         errors++;
         $display("FAIL back_to_back_timing: pulses=%0d bad_gaps=%0d want 3 0", pulses, bad_gap);
      end
      checks++;
      if (bad_diff !== 0) begin
         errors++;
         $display("FAIL back_to_back_diff: %0d cycles diff!=10 want 0", bad_diff);
      end
   endtask

   task automatic test_reset_mid();
      int dones;
      start = 1'b1;
      a = 8'h80;
      b = 8'h01;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: ready=%b done=%b diff=%h borrow=%b want 1 0 00 0",
                  ready, done, diff, borrow);
      end
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done) dones++;
      end
      checks++;
      if (dones !== 0 || diff !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_no_done: dones=%0d diff=%h want 0 00", dones, diff);
      end
      run_op(8'h09, 8'h04);
      checks++;
      if (r_done_cnt !== 1 || r_diff !== 8'h05 || r_borrow !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_fresh: diff=%h borrow=%b dones=%0d want 05 0 1",
                  r_diff, r_borrow, r_done_cnt);
      end
   endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   task automatic test_ovf();
      run_op(8'h80, 8'h01);
      checks++;
      if (r_diff !== 8'h7F || r_borrow !== 1'b0 || r_ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_neg_minus_pos: diff=%h borrow=%b ovf=%b want 7f 0 1", r_diff, r_borrow, r_ovf);
      end
      run_op(8'h7F, 8'hFF);
      checks++;
      if (r_diff !== 8'h80 || r_borrow !== 1'b1 || r_ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_pos_minus_neg: diff=%h borrow=%b ovf=%b want 80 1 1", r_diff, r_borrow, r_ovf);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_reset: ovf=%b want 0", ovf);
      end
      run_op(8'h05, 8'h03);
      checks++;
      if (r_diff !== 8'h02 || r_ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_none: diff=%h ovf=%b want 02 0", r_diff, r_ovf);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      tick();
      test_reset();
      test_basic();
      test_patterns();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      test_ovf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial, LSB-first N-bit subtractor computing diff = a - b with borrow-out, using one full-subtractor cell and a borrow flip-flop iterated over WIDTH cycles. It is the subtract-direction counterpart to the team's adder cells. It serves area-constrained datapaths that can tolerate WIDTH+1 cycles of latency. It has a start/done handshake so a simple controller FSM can drive it.

Parameters:
WIDTH, 8, operand/result width in bits (legal range >= 1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
a  input  WIDTH  minuend, sampled on the accepting edge
b  input  WIDTH  subtrahend, sampled on the accepting edge
ready  output  1  high only in IDLE
diff  output  WIDTH  result a - b mod 2^WIDTH
borrow  output  1  1 when a < b (unsigned)
done  output  1  one-cycle pulse; diff/borrow valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: state=IDLE, ready=1, done=0, diff=0, borrow=0, shift registers=0, bit counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT when start=1 (in IDLE, ready=1). On that edge:
  - capture a into sa and b into sb;
  - clear borrow_ff and the counter;
  - diff and borrow keep their previous values until DONE.
- SHIFT, one bit per cycle, with x=sa[0], y=sb[0], br=borrow_ff:
  - d = x ^ y ^ br
  - br_next = (~x & y) | (~(x ^ y) & br)
  - shift d into the MSB of the result register;
  - shift sa and sb right by one;
  - increment the counter.
  - When the counter reaches WIDTH-1 on the processing edge, go to DONE, load diff from the result register, and load borrow from br_next.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: accept edge T0; bits are processed on edges T0+1 .. T0+WIDTH; done is high in the cycle between edges T0+WIDTH and T0+WIDTH+1. ready is low for WIDTH+1 cycles.
- Holding: diff and borrow hold until the next completion. They are not cleared on a new start.
- start while ready=0 (SHIFT or DONE): ignored. No queuing. a and b changing mid-operation have no effect.
- start held high continuously: the next operation is accepted on the first edge in IDLE after DONE, giving a throughput of one result per WIDTH+2 cycles.
- rst mid-operation (any state): abort. The next cycle shows reset values (ready=1, done=0, diff=0, borrow=0). No partial result is ever published.
- rst and start both high: reset wins; the operation is not accepted.
- WIDTH=1: SHIFT lasts one cycle, and diff = a^b, borrow = ~a&b.
- Counter width: max(1, clog2(WIDTH)) bits. The counter must not wrap before the terminal compare.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- When defined: adds output port ovf (1 bit, reset 0), the two's-complement overflow flag, registered with diff on the same edge.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), evaluated on the captured operands.
  - ovf holds with diff and is cleared by rst.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, then start with a=0x05, b=0x03 (WIDTH=8) -> done pulses exactly 9 cycles after the accept edge; diff=0x02, borrow=0; ready low for 9 cycles, then high.
2. a=0x03, b=0x05 -> diff=0xFE, borrow=1. a=0x00, b=0x01 -> diff=0xFF, borrow=1. a=0xFF, b=0xFF -> diff=0x00, borrow=0. a=0x00, b=0x00 -> diff=0x00, borrow=0.
3. Start with a=0x10, b=0x01; pulse start again at cycle 3 with a=0xAA, b=0x55 -> second request ignored; result diff=0x0F, borrow=0; exactly one done pulse.
4. start held high with a=0x20, b=0x10 constant -> done pulses every 10 cycles, diff=0x10 each time; diff unchanged between pulses.
5. Accept a=0x80, b=0x01; assert rst for one cycle at the 4th SHIFT cycle -> next cycle ready=1, done=0, diff=0x00, borrow=0, and no done pulse follows. A fresh a=0x09, b=0x04 then yields diff=0x05, borrow=0.
6. With SERIAL_SUBTRACTOR_OVF_EN defined:
   - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
   - a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
   - a=0x05, b=0x03 -> ovf=0.
   - rst clears ovf to 0.
